// File: rtl/voice_path_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : voice_path_ctrl                                                 |
// | Purpose  : Frame-synchronised capture of CH codec channels, sequencing     |
// |            through a shared effect engine and dry/wet crossfade to codec.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module voice_path_ctrl #(
  parameter int CH        = 2,
  parameter int CW        = 24,
  parameter int DW        = 16,
  parameter int RAMP_LOG2 = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_frame,
  input  logic [CH*CW-1:0]     rec_data,
  input  logic                 change_en,
  output logic                 proc_req,
  output logic [2:0]           proc_ch,
  output logic [DW-1:0]        proc_x,
  input  logic                 proc_ack,
  input  logic [DW-1:0]        proc_y,
  output logic [CH*CW-1:0]     play_data,
  output logic                 play_valid,
  output logic [RAMP_LOG2:0]   gain,
  output logic                 overrun
);

  localparam int                 c_pw   = DW + RAMP_LOG2 + 2;
  localparam logic [RAMP_LOG2:0] c_full = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [2:0]         c_last = 3'(CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_MIX  = 2'd2
  } state_t;

  state_t              r_state, w_next;
  logic                r_s1, r_s2, r_s3;
  logic                w_strobe, w_last;
  logic [2:0]          r_ch;
  logic [CW-1:0]       r_cap [CH];
  logic [DW-1:0]       r_wet [CH];
  logic [CH*CW-1:0]    r_play, w_mixed;
  logic                r_play_valid;
  logic [RAMP_LOG2:0]  r_g;
  logic                r_overrun;

  assign w_strobe   = r_s2 & ~r_s3;
  assign w_last     = (r_ch == c_last);
  assign proc_ch    = r_ch;
  assign play_data  = r_play;
  assign play_valid = r_play_valid;
  assign gain       = r_g;
  assign overrun    = r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    proc_req = 1'b0;
    proc_x   = '0;
    for (int i = 0; i < CH; i++)
      if (r_ch == 3'(i)) proc_x = r_cap[i][CW-1 -: DW];
    case (r_state)
      ST_IDLE: if (w_strobe) w_next = ST_REQ;
      ST_REQ: begin
        proc_req = 1'b1;
        if (proc_ack && w_last) w_next = ST_MIX;
      end
      ST_MIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-channel weighted mix; weights sum to 2^RAMP_LOG2 so the shifted sum fits DW.
  for (genvar i = 0; i < CH; i++) begin : g_mix
    logic signed [DW-1:0]    w_dry, w_wet;
    logic        [RAMP_LOG2:0] w_wd_raw;
    logic signed [c_pw-1:0]  w_dx, w_wx, w_wd, w_wg, w_sum, w_shift;
    logic        [DW-1:0]    w_out;

    assign w_dry    = r_cap[i][CW-1 -: DW];
    assign w_wet    = r_wet[i];
    assign w_wd_raw = c_full - r_g;
    assign w_dx     = {{(c_pw-DW){w_dry[DW-1]}}, w_dry};
    assign w_wx     = {{(c_pw-DW){w_wet[DW-1]}}, w_wet};
    assign w_wd     = {{(c_pw-RAMP_LOG2-1){1'b0}}, w_wd_raw};
    assign w_wg     = {{(c_pw-RAMP_LOG2-1){1'b0}}, r_g};
    assign w_sum    = w_dx * w_wd + w_wx * w_wg;
    assign w_shift  = w_sum >>> RAMP_LOG2;
    assign w_out    = w_shift[DW-1:0];

    if (CW > DW) begin : g_pad
      assign w_mixed[i*CW +: CW] = (r_g == '0) ? r_cap[i] : {w_out, {(CW-DW){1'b0}}};
    end else begin : g_nopad
      assign w_mixed[i*CW +: CW] = (r_g == '0) ? r_cap[i] : w_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_ch         <= '0;
      r_play       <= '0;
      r_play_valid <= 1'b0;
      r_g          <= '0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_cap[i] <= '0;
        r_wet[i] <= '0;
      end
    end else begin
      r_s1         <= new_frame;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      r_play_valid <= 1'b0;
      // A frame arriving while a previous one is in flight is dropped.
      if (w_strobe && r_state != ST_IDLE) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_strobe) begin
          for (int i = 0; i < CH; i++) r_cap[i] <= rec_data[i*CW +: CW];
          r_ch <= '0;
        end
        ST_REQ: if (proc_ack) begin
          for (int i = 0; i < CH; i++)
            if (r_ch == 3'(i)) r_wet[i] <= proc_y;
          if (!w_last) r_ch <= r_ch + 3'd1;
        end
        ST_MIX: begin
          r_play       <= w_mixed;
          r_play_valid <= 1'b1;
          r_ch         <= '0;
          if (change_en) begin
            if (r_g != c_full) r_g <= r_g + 1'b1;
          end else if (r_g != '0) begin
            r_g <= r_g - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
